// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared playfield constants, row type and line-clear state encoding
package tetris_pkg;

   localparam int ROWS        = 20;
   localparam int COLS        = 10;
   localparam int CELL_W      = 4;
   localparam int LC_CNT_MAX  = 4;

   typedef logic [COLS*CELL_W-1:0] row_t;

   typedef enum logic [2:0] {
      LC_IDLE   = 3'd0,
      LC_SCAN   = 3'd1,
      LC_FLASH  = 3'd2,
      LC_CMP_RD = 3'd3,
      LC_CMP_WR = 3'd4,
      LC_ZERO   = 3'd5,
      LC_FIN    = 3'd6
   } lc_state_t;

endpackage

// File: rtl/row_full_detect.sv
// rtl/row_full_detect.sv - combinational check that every cell of a row is occupied
module row_full_detect
   import tetris_pkg::*;
#(
   parameter int COLS   = tetris_pkg::COLS,
   parameter int CELL_W = tetris_pkg::CELL_W
) (
   input  logic [COLS*CELL_W-1:0] row_i,
   output logic                   full_o
);

   always_comb begin
      full_o = 1'b1;
      for (int c = 0; c < COLS; c++) begin
         if (row_i[c*CELL_W +: CELL_W] == '0) full_o = 1'b0;
      end
   end

endmodule

// File: rtl/line_clear_ctrl.sv
// rtl/line_clear_ctrl.sv - post-lock sequencer: scan full rows, blink them, compact the playfield
module line_clear_ctrl
   import tetris_pkg::*;
#(
   parameter int ROWS        = tetris_pkg::ROWS,
   parameter int COLS        = tetris_pkg::COLS,
   parameter int CELL_W      = tetris_pkg::CELL_W,
   parameter int FLASH_TICKS = 12
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic                   frame_tick,
   output logic                   busy,
   output logic                   done,
   output logic [2:0]             lines_cleared,
   output logic [ROWS-1:0]        flash_mask,
   output logic [4:0]             rd_addr,
   input  logic [COLS*CELL_W-1:0] rd_data,
   output logic                   wr_en,
   output logic [4:0]             wr_addr,
   output logic [COLS*CELL_W-1:0] wr_data
);

   localparam int               TW        = $clog2(FLASH_TICKS + 1);
   localparam logic [TW-1:0]    TICK_LAST = TW'(FLASH_TICKS - 1);
   localparam logic [4:0]       SCAN_LAST = 5'(ROWS);
   localparam logic signed [5:0] ROW_LAST = 6'(ROWS - 1);
   localparam logic [2:0]       CNT_MAX   = 3'(LC_CNT_MAX);

   lc_state_t         state_q, state_d;
   logic [4:0]        scnt_q, scnt_d;
   logic [ROWS-1:0]   full_mask_q, full_mask_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [TW-1:0]     ticks_q, ticks_d;
   logic              phase_q, phase_d;
   logic signed [5:0] src_q, src_d, dst_q, dst_d;
   logic              busy_q, busy_d, done_q, done_d;
   logic [2:0]        lc_q, lc_d;
   logic              row_full;
   logic [4:0]        src_idx;

   assign src_idx       = src_q[4:0];
   assign busy          = busy_q;
   assign done          = done_q;
   assign lines_cleared = lc_q;

   row_full_detect #(.COLS(COLS), .CELL_W(CELL_W)) u_row_full_detect (
      .row_i  (rd_data),
      .full_o (row_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= LC_IDLE;
         scnt_q      <= '0;
         full_mask_q <= '0;
         cnt_q       <= '0;
         ticks_q     <= '0;
         phase_q     <= 1'b1;
         src_q       <= '0;
         dst_q       <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         lc_q        <= '0;
      end else begin
         state_q     <= state_d;
         scnt_q      <= scnt_d;
         full_mask_q <= full_mask_d;
         cnt_q       <= cnt_d;
         ticks_q     <= ticks_d;
         phase_q     <= phase_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         lc_q        <= lc_d;
      end
   end

   // done_q is high in the first IDLE cycle, so a start coinciding with done is dropped
   always_comb begin
      state_d = state_q;
      case (state_q)
         LC_IDLE:   if (start && !done_q) state_d = LC_SCAN;
         LC_SCAN:   if (scnt_q == SCAN_LAST) state_d = (cnt_d == 3'd0) ? LC_FIN : LC_FLASH;
         LC_FLASH:  if (frame_tick && ticks_q == TICK_LAST) state_d = LC_CMP_RD;
         LC_CMP_RD: begin
            if (src_q[5])                     state_d = LC_ZERO;
            else if (!full_mask_q[src_idx])   state_d = LC_CMP_WR;
         end
         LC_CMP_WR: state_d = LC_CMP_RD;
         LC_ZERO:   if (dst_q == 6'sd0) state_d = LC_FIN;
         LC_FIN:    state_d = LC_IDLE;
         default:   state_d = LC_IDLE;
      endcase
   end

   always_comb begin
      scnt_d      = scnt_q;
      full_mask_d = full_mask_q;
      cnt_d       = cnt_q;
      ticks_d     = ticks_q;
      phase_d     = phase_q;
      src_d       = src_q;
      dst_d       = dst_q;
      lc_d        = lc_q;
      busy_d      = (state_d != LC_IDLE) || (state_q == LC_FIN);
      done_d      = (state_q == LC_FIN);
      case (state_q)
         LC_IDLE: begin
            if (state_d == LC_SCAN) begin
               scnt_d      = '0;
               full_mask_d = '0;
               cnt_d       = '0;
            end
         end
         LC_SCAN: begin
            scnt_d  = scnt_q + 5'd1;
            ticks_d = '0;
            phase_d = 1'b1;
            // rd_data here belongs to the row addressed one cycle earlier
            if (scnt_q != 5'd0 && row_full) begin
               full_mask_d[scnt_q - 5'd1] = 1'b1;
               if (cnt_q < CNT_MAX) cnt_d = cnt_q + 3'd1;
            end
         end
         LC_FLASH: begin
            if (frame_tick) begin
               phase_d = ~phase_q;
               ticks_d = ticks_q + TW'(1);
            end
            if (state_d == LC_CMP_RD) begin
               src_d = ROW_LAST;
               dst_d = ROW_LAST;
            end
         end
         LC_CMP_RD: if (!src_q[5] && full_mask_q[src_idx]) src_d = src_q - 6'sd1;
         LC_CMP_WR: begin
            src_d = src_q - 6'sd1;
            dst_d = dst_q - 6'sd1;
         end
         LC_ZERO:   dst_d = dst_q - 6'sd1;
         LC_FIN:    lc_d  = cnt_q;
         default: ;
      endcase
   end

   always_comb begin
      rd_addr    = '0;
      wr_en      = 1'b0;
      wr_addr    = '0;
      wr_data    = '0;
      flash_mask = '0;
      case (state_q)
         LC_SCAN:   if (scnt_q < SCAN_LAST) rd_addr = scnt_q;
         LC_FLASH:  if (phase_q) flash_mask = full_mask_q;
         LC_CMP_RD: if (!src_q[5] && !full_mask_q[src_idx]) rd_addr = src_idx;
         LC_CMP_WR: begin
            wr_en   = 1'b1;
            wr_addr = dst_q[4:0];
            wr_data = rd_data;
         end
         LC_ZERO: begin
            wr_en   = 1'b1;
            wr_addr = dst_q[4:0];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_line_clear_ctrl.sv
// tb/tb_line_clear_ctrl.sv - scoreboard bench for line_clear_ctrl with a behavioural playfield RAM
module tb_line_clear_ctrl;
   import tetris_pkg::*;

   localparam int FT = 4;
   typedef logic [ROWS-1:0][COLS*CELL_W-1:0] img_t;
   typedef struct packed {
      logic [2:0]  lc;
      logic [15:0] lat;
      img_t        img;
   } exp_t;

   localparam logic [39:0] FULL_A = 40'h123456789A;
   localparam logic [39:0] PAT_A  = 40'h0102030405;
   localparam logic [39:0] PAT_B  = 40'h00000000B0;
   localparam logic [39:0] PAT_C  = 40'h0C00000000;
   localparam logic [39:0] PAT_D  = 40'h000000000D;

   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, frame_tick = 1'b0;
   logic busy, done, wr_en;
   logic [2:0] lines_cleared;
   logic [ROWS-1:0] flash_mask;
   logic [4:0] rd_addr, wr_addr;
   row_t rd_data, wr_data;
   img_t ram, init_img, img, expd;
   logic load = 1'b0;
   exp_t exp_q[$];
   exp_t mon_e;
   int checks = 0, errors = 0, cyc = 0, start_cyc = 0, done_seen = 0;
   int wr_seen = 0, fm_seen = 0;

   line_clear_ctrl #(.FLASH_TICKS(FT)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .frame_tick(frame_tick),
      .busy(busy), .done(done), .lines_cleared(lines_cleared), .flash_mask(flash_mask),
      .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      rd_data <= ram[rd_addr];
      if (load) ram <= init_img;
      else if (wr_en) ram[wr_addr] <= wr_data;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && wr_en) wr_seen++;
      if (rst_n && flash_mask != '0) fm_seen++;
      if (rst_n && done) begin
         done_seen++;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done actual=done required=no_done");
         end else begin
            mon_e = exp_q.pop_front();
            chk("lines_cleared", 64'(lines_cleared), 64'(mon_e.lc));
            chk("busy_at_done", 64'(busy), 64'd1);
            if (mon_e.lat != 16'hFFFF) chk("latency", 64'(cyc - start_cyc), 64'(mon_e.lat));
            for (int r = 0; r < ROWS; r++)
               chk($sformatf("ram_row%0d", r), 64'(ram[r]), 64'(mon_e.img[r]));
         end
      end
   end

   task automatic load_img(input img_t im);
      @(posedge clk); #1;
      init_img = im;
      load = 1'b1;
      @(posedge clk); #1;
      load = 1'b0;
   endtask

   task automatic push(input logic [2:0] lc, input logic [15:0] lat, input img_t im);
      exp_t e;
      e.lc = lc; e.lat = lat; e.img = im;
      exp_q.push_back(e);
   endtask

   task automatic pulse_start();
      @(posedge clk); #1;
      start = 1'b1;
      start_cyc = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
      frame_tick = 1'b1;
      @(posedge clk); #1;
      frame_tick = 1'b0;
   endtask

   task automatic wait_done(input int target, input int maxc);
      int n = 0;
      while (done_seen < target && n < maxc) begin
         @(posedge clk);
         n++;
      end
      chk("wait_done", 64'(done_seen), 64'(target));
   endtask

   task automatic wait_wr(input int maxc);
      int n = 0;
      @(negedge clk);
      while (!wr_en && n < maxc) begin
         @(negedge clk);
         n++;
      end
      chk("wait_wr_en", 64'(wr_en), 64'd1);
   endtask

   task automatic run_with_flash();
      pulse_start();
      repeat (24) @(posedge clk);
      repeat (FT) tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_wr_en"}, 64'(wr_en), 64'd0);
      chk({tag, "_lines"}, 64'(lines_cleared), 64'd0);
      chk({tag, "_flash"}, 64'(flash_mask), 64'd0);
      chk({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
      chk({tag, "_wr_addr"}, 64'(wr_addr), 64'd0);
      chk({tag, "_wr_data"}, 64'(wr_data), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      init_img = '0;
      load = 1'b1;
      repeat (3) @(posedge clk);
      #1 load = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk); #1 rst_n = 1'b1;

      // empty grid
      load_img('0);
      wr_seen = 0; fm_seen = 0;
      push(3'd0, 16'd23, '0);
      pulse_start();
      wait_done(1, 200);
      chk("t1_no_wr_en", 64'(wr_seen), 64'd0);
      chk("t1_no_flash", 64'(fm_seen), 64'd0);

      // single full row, blink pattern, stray tick during scan
      img = '0; img[19] = FULL_A; img[18] = PAT_A;
      expd = '0; expd[19] = PAT_A;
      load_img(img);
      wr_seen = 0;
      push(3'd1, 16'hFFFF, expd);
      pulse_start();
      tick();
      repeat (20) @(posedge clk);
      @(negedge clk); chk("t2_flash_on0", 64'(flash_mask), 64'(20'h80000));
      tick(); @(negedge clk); chk("t2_flash_off1", 64'(flash_mask), 64'd0);
      tick(); @(negedge clk); chk("t2_flash_on2", 64'(flash_mask), 64'(20'h80000));
      tick(); @(negedge clk); chk("t2_flash_off3", 64'(flash_mask), 64'd0);
      @(negedge clk); @(negedge clk);
      chk("t2_still_flash", 64'(wr_seen), 64'd0);
      tick(); @(negedge clk); chk("t2_flash_exit", 64'(flash_mask), 64'd0);
      wait_done(2, 500);

      // tetris plus ignored starts in FLASH and CMP_WR
      img = '0;
      img[16] = 40'h1111111111; img[17] = 40'h2222222222;
      img[18] = 40'h3333333333; img[19] = 40'h4444444444;
      img[12] = 40'h0000000001; img[13] = 40'h0000000020;
      img[14] = 40'h0000000300; img[15] = 40'h0000004000;
      expd = '0;
      expd[16] = 40'h0000000001; expd[17] = 40'h0000000020;
      expd[18] = 40'h0000000300; expd[19] = 40'h0000004000;
      load_img(img);
      push(3'd4, 16'hFFFF, expd);
      pulse_start();
      repeat (24) @(posedge clk);
      pulse_start();
      repeat (FT) tick();
      wait_wr(100);
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      wait_done(3, 500);
      repeat (100) @(posedge clk);
      chk("t3_single_done", 64'(done_seen), 64'd3);

      // non-contiguous full rows
      img = '0; img[19] = FULL_A; img[17] = FULL_A; img[18] = PAT_B; img[16] = PAT_C;
      expd = '0; expd[19] = PAT_B; expd[18] = PAT_C;
      load_img(img);
      push(3'd2, 16'hFFFF, expd);
      run_with_flash();
      wait_done(4, 500);

      // five full rows saturate the count
      img = '0; img[0] = PAT_D;
      for (int r = 15; r < 20; r++) img[r] = FULL_A;
      expd = '0; expd[5] = PAT_D;
      load_img(img);
      push(3'd4, 16'hFFFF, expd);
      run_with_flash();
      wait_done(5, 500);

      // asynchronous reset in CMP_WR, then a fresh run
      img = '0; img[19] = FULL_A; img[17] = FULL_A; img[18] = PAT_B; img[16] = PAT_C;
      expd = '0; expd[19] = PAT_B; expd[18] = PAT_C;
      load_img(img);
      push(3'd2, 16'hFFFF, expd);
      run_with_flash();
      wait_wr(100);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async_rst");
      exp_q.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      load_img(img);
      push(3'd2, 16'hFFFF, expd);
      run_with_flash();
      wait_done(6, 500);
      chk("sb_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
